instr_encoder: RTL

Field-to-word instruction encoder for the 16-bit TSC-style ISA. It accepts decoded fields (opcode, register numbers, function code, 16-bit signed immediate) over a valid/ready handshake and packs them into a 16-bit instruction word. For I-type words it narrows the immediate to the signed 8-bit field; for JMP/JAL it narrows to the signed 12-bit target field, flagging out-of-range immediates and illegal opcodes. Words are buffered in a 2-entry FIFO and emitted with a sequential memory address. The block sits between the test/boot loader and instruction memory.

---
 rtl/tsc_defs.sv | 32 +++
 rtl/sync_fifo2.sv | 63 ++++++
 rtl/instr_encoder.sv | 99 +++++++++
 3 files changed

// File: rtl/tsc_defs.sv
// Shared ISA constants and helpers for the 16-bit TSC instruction encoder.
package tsc_defs;

  localparam logic [3:0] OP_RTYPE  = 4'd15;
  localparam logic [3:0] OP_JMP    = 4'd9;
  localparam logic [3:0] OP_JAL    = 4'd10;
  localparam logic [3:0] OP_I_LAST = 4'd8;

  // Field layout: op[15:12] rs[11:10] rt[9:8] rd[7:6] func[5:0] / imm8[7:0] / imm12[11:0]
  localparam int unsigned IMM_I_W = 8;
  localparam int unsigned IMM_J_W = 12;

  typedef enum logic [1:0] {
    FMT_I,
    FMT_R,
    FMT_J,
    FMT_ILL
  } fmt_e;

  typedef struct packed {
    logic        err;
    logic [15:0] instr;
  } fifo_entry_t;

  // Sign-extend the low w bits of v to 16 bits.
  function automatic logic [15:0] sign_extend(input logic [15:0] v, input int unsigned w);
    logic signed [15:0] s;
    s = $signed(v << (16 - w));
    return s >>> (16 - w);
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry FIFO of encoded words with error flag; flush empties it in one cycle.
module sync_fifo2
  import tsc_defs::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  fifo_entry_t wdata,
  output fifo_entry_t rdata,
  output logic [1:0]  count
);

  fifo_entry_t mem_q [2];
  fifo_entry_t mem_d [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        push_ok, pop_ok;

  assign push_ok = push && (count_q != 2'd2);
  assign pop_ok  = pop && (count_q != 2'd0);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Empty FIFO presents zeros so the word outputs read as 0 when nothing is held.
  assign rdata = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded TSC fields into 16-bit words, range-checks immediates, and
// streams them with sequential addresses through a 2-entry FIFO.
module instr_encoder
  import tsc_defs::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [1:0]        in_rs,
  input  logic [1:0]        in_rt,
  input  logic [1:0]        in_rd,
  input  logic [5:0]        in_func,
  input  logic [15:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  fmt_e              fmt;
  fifo_entry_t       enc;
  fifo_entry_t       head;
  logic [1:0]        count;
  logic              push, pop;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        err_count_q, err_count_d;

  always_comb begin
    if (in_opcode == OP_RTYPE)                            fmt = FMT_R;
    else if (in_opcode == OP_JMP || in_opcode == OP_JAL)  fmt = FMT_J;
    else if (in_opcode <= OP_I_LAST)                      fmt = FMT_I;
    else                                                  fmt = FMT_ILL;
  end

  always_comb begin
    enc = '0;
    case (fmt)
      FMT_R: enc.instr = {in_opcode, in_rs, in_rt, in_rd, in_func};
      FMT_J: begin
        enc.instr = {in_opcode, in_imm[IMM_J_W-1:0]};
        enc.err   = (in_imm != sign_extend(in_imm, IMM_J_W));
      end
      FMT_I, FMT_ILL: begin
        enc.instr = {in_opcode, in_rs, in_rt, in_imm[IMM_I_W-1:0]};
        enc.err   = (fmt == FMT_ILL) || (in_imm != sign_extend(in_imm, IMM_I_W));
      end
    endcase
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !restart;
  assign pop       = out_valid && out_ready && !restart;

  sync_fifo2 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (restart),
    .push    (push),
    .pop     (pop),
    .wdata   (enc),
    .rdata   (head),
    .count   (count)
  );

  always_comb begin
    addr_d      = addr_q;
    err_count_d = err_count_q;
    if (restart)  addr_d = BASE;
    else if (pop) addr_d = addr_q + 1'b1;
    if (push && enc.err && err_count_q != '1) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= BASE;
      err_count_q <= '0;
    end else begin
      addr_q      <= addr_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_instr = head.instr;
  assign out_err   = head.err;
  assign out_addr  = addr_q;
  assign err_count = err_count_q;

endmodule
